timer_intc: RTL and testbench
=============================

Name: timer_intc

Overview:
Interrupt controller directly downstream of the 8-bit timer. It consumes the timer's overflow (of) and underflow (uf) status flags and latches them as pending interrupts. It applies per-source masks, counts events, and drives a single CPU interrupt line. It is an APB slave on the same bus as the timer, decoded at its own base by the system fabric.

Parameters:
ADDR_WIDTH, 8, APB address width
DATA_WIDTH, 8, APB data width
CNT_WIDTH, 8, width of each per-source saturating event counter

Ports:
pclk  input  1  APB/system clock
preset_n  input  1  asynchronous active-low reset
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_WIDTH  register address (offset)
pwdata  input  DATA_WIDTH  write data
prdata  output  DATA_WIDTH  read data
pready  output  1  transfer complete
pslverr  output  1  unmapped-address error
of_i  input  1  timer overflow flag (timer TSR[0], sticky level)
uf_i  input  1  timer underflow flag (timer TSR[1], sticky level)
irq  output  1  interrupt request to CPU

Behaviour:
- Clock and reset: one clock, pclk. Reset is asynchronous and active-low on preset_n. All flops clear on preset_n=0 at any time, including mid-transfer. Reset values: prdata=0, pready=0, pslverr=0, irq=0, all registers 0.
- Register map:
  - 0x00 IER[1:0]: bit0 enables of, bit1 enables uf. Read/write; bits 7:2 read 0.
  - 0x01 IPR[1:0]: pending bits. Writing 0 to a bit clears it; writing 1 leaves it unchanged (same write-0-to-clear convention as the timer TSR).
  - 0x02 ICR: bit0 GIE (global enable); bit1 MODE (0 = level irq, 1 = pulse irq). Read/write.
  - 0x03 OFCNT and 0x04 UFCNT: read-only event counters. Any write to the address clears that counter.
  - Any other address: pslverr=1 in the access cycle, writes ignored, prdata=0.
- APB FSM with states IDLE, SETUP, ACCESS:
  - IDLE→SETUP when psel=1 and penable=0.
  - SETUP→ACCESS on the next cycle, with penable=1.
  - ACCESS→IDLE, or →SETUP if psel stays high with penable low.
  - pready=1 only in the ACCESS cycle, giving zero wait states.
  - Register writes commit at the pclk edge ending ACCESS.
  - prdata is registered and valid during ACCESS; 0 otherwise.
  - psel/penable deasserted mid-transfer: return to IDLE, no register update.
- Event detection:
  - A rising edge of of_i/uf_i, registered against the previous-cycle value, is an event. A level that stays high is not a repeat event.
  - On an event: set the IPR bit and increment the matching counter (+1), saturating at 2^CNT_WIDTH-1 with no wrap.
  - Latency: of_i rises at edge N → IPR set after edge N+1.
- Simultaneous events:
  - Event and write-0-clear of the same IPR bit in the same cycle: the set wins and the bit stays 1.
  - Event and counter-clear write in the same cycle: counter = 1.
  - of and uf events in the same cycle: both latch.
- irq output:
  - Level mode (MODE=0): irq = GIE & |(IPR & IER), registered, so one cycle after IPR updates.
  - Pulse mode (MODE=1): irq is a one-cycle pulse when any enabled IPR bit goes 0→1 while GIE=1. No pulse for a bit that was already pending.
  - IER or GIE enabled while a bit is already pending: level mode asserts irq on the next cycle; pulse mode does not pulse.

Decomposition:
- Shared package timer_pkg holds:
  - Register offset constants: TIMER_TDR/TCR/TSR and INTC_IER/IPR/ICR/OFCNT/UFCNT.
  - Bit-index constants OF_BIT=0 and UF_BIT=1.
  - The APB state enum {IDLE, SETUP, ACCESS}.
- One natural sub-module: intc_evt_cnt, a saturating counter with inc and clr inputs (clr and inc together loads 1), instantiated twice.

Test Plan:
- Reset and defaults: preset_n low 50 ns, then read 0x00–0x04 → all 0x00; irq=0; pslverr=0.
- Overflow in level mode: write IER=0x01, ICR=0x01. Timer loaded 0xF0, counting up to wrap, so of_i rises → IPR=0x01, OFCNT=0x01, irq=1 two cycles after of_i. Write IPR=0x02 (clears bit0) → irq=0 next cycle.
- Masking: IER=0x01, trigger uf_i → IPR=0x02, UFCNT=0x01, irq stays 0. Then write IER=0x03 → irq=1 next cycle.
- Pulse mode, simultaneous and held edges: ICR=0x03, IER=0x03, drive of_i and uf_i high in the same cycle → IPR=0x03, irq high exactly 1 cycle. Hold inputs high → no further pulse and counters unchanged.
- Set-beats-clear and saturation: assert an of_i edge in the same cycle as a write IPR=0x00 → IPR[0]=1. Generate 260 of edges → OFCNT=0xFF. Write 0x03 → OFCNT=0x00.
- Error and mid-op reset: access 0x07 → pslverr=1, pready=1, no state change. Assert preset_n mid-ACCESS → all outputs 0 immediately, and a subsequent read of IPR returns 0x00.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared timer/interrupt-controller definitions: register offsets, flag bit
// positions and the APB phase encoding.
package timer_pkg;

    localparam logic [7:0] TIMER_TDR   = 8'h00;
    localparam logic [7:0] TIMER_TCR   = 8'h01;
    localparam logic [7:0] TIMER_TSR   = 8'h02;

    localparam logic [7:0] INTC_IER    = 8'h00;
    localparam logic [7:0] INTC_IPR    = 8'h01;
    localparam logic [7:0] INTC_ICR    = 8'h02;
    localparam logic [7:0] INTC_OFCNT  = 8'h03;
    localparam logic [7:0] INTC_UFCNT  = 8'h04;

    localparam int OF_BIT = 0;
    localparam int UF_BIT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/intc_evt_cnt.sv
// Saturating event counter; a clear coinciding with an increment loads 1 so
// that the event is never lost.
module intc_evt_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && cnt != {W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timer_intc.sv
// Interrupt controller for the 8-bit timer: latches of/uf rising edges as
// pending bits, masks them, counts them, and drives a level or pulse irq.
module timer_intc
    import timer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic                  of_i,
    input  logic                  uf_i,
    output logic                  irq
);

    apb_state_t            state;
    logic [1:0]            ier, ipr, ipr_d, lvl_q, evt, ipr_n;
    logic                  gie, mode;
    logic [CNT_WIDTH-1:0]  ofcnt, ufcnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  setup_ph, commit, mapped;
    logic                  wr_ier, wr_ipr, wr_icr, wr_ofcnt, wr_ufcnt;
    logic                  unused_wdata;

    assign unused_wdata = ^pwdata[DATA_WIDTH-1:2];

    assign evt      = {uf_i, of_i} & ~lvl_q;
    assign setup_ph = psel & ~penable;
    // state holds the phase sampled at the previous edge, so SETUP here
    // coincides with the bus access cycle and this edge ends it.
    assign commit   = (state == SETUP) & psel & penable & pwrite;
    assign mapped   = paddr <= ADDR_WIDTH'(INTC_UFCNT);
    assign wr_ier   = commit & (paddr == ADDR_WIDTH'(INTC_IER));
    assign wr_ipr   = commit & (paddr == ADDR_WIDTH'(INTC_IPR));
    assign wr_icr   = commit & (paddr == ADDR_WIDTH'(INTC_ICR));
    assign wr_ofcnt = commit & (paddr == ADDR_WIDTH'(INTC_OFCNT));
    assign wr_ufcnt = commit & (paddr == ADDR_WIDTH'(INTC_UFCNT));

    // Event set is OR-ed after the write-0-clear so a same-cycle event wins.
    assign ipr_n = (wr_ipr ? (ipr & pwdata[1:0]) : ipr) | evt;

    always_comb begin
        rd_data = '0;
        if (paddr == ADDR_WIDTH'(INTC_IER))        rd_data = DATA_WIDTH'(ier);
        else if (paddr == ADDR_WIDTH'(INTC_IPR))   rd_data = DATA_WIDTH'(ipr);
        else if (paddr == ADDR_WIDTH'(INTC_ICR))   rd_data = DATA_WIDTH'({mode, gie});
        else if (paddr == ADDR_WIDTH'(INTC_OFCNT)) rd_data = DATA_WIDTH'(ofcnt);
        else if (paddr == ADDR_WIDTH'(INTC_UFCNT)) rd_data = DATA_WIDTH'(ufcnt);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            if (setup_ph) begin
                state   <= SETUP;
                pready  <= 1'b1;
                pslverr <= ~mapped;
                prdata  <= rd_data;
            end else begin
                case (state)
                    SETUP:   state <= (psel & penable) ? ACCESS : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ier   <= '0;
            gie   <= 1'b0;
            mode  <= 1'b0;
            ipr   <= '0;
            ipr_d <= '0;
            lvl_q <= '0;
            irq   <= 1'b0;
        end else begin
            if (wr_ier) ier <= pwdata[1:0];
            if (wr_icr) {mode, gie} <= pwdata[1:0];
            ipr   <= ipr_n;
            ipr_d <= ipr;
            lvl_q <= {uf_i, of_i};
            // Pulse mode looks only at fresh 0->1 pending transitions.
            irq   <= gie & (mode ? |(ipr & ~ipr_d & ier) : |(ipr & ier));
        end
    end

    intc_evt_cnt #(.W(CNT_WIDTH)) u_of_cnt (
        .clk   (pclk),
        .rst_n (preset_n),
        .inc   (evt[OF_BIT]),
        .clr   (wr_ofcnt),
        .cnt   (ofcnt)
    );

    intc_evt_cnt #(.W(CNT_WIDTH)) u_uf_cnt (
        .clk   (pclk),
        .rst_n (preset_n),
        .inc   (evt[UF_BIT]),
        .clr   (wr_ufcnt),
        .cnt   (ufcnt)
    );

endmodule

// File: tb/tb_timer_intc.sv
// Directed bench for timer_intc: APB access, event latching, masking,
// level/pulse irq, set-beats-clear, saturation, errors and async reset.
module tb_timer_intc;
    import timer_pkg::*;

    logic       pclk = 1'b0;
    logic       preset_n = 1'b0;
    logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0] paddr = '0, pwdata = '0;
    logic [7:0] prdata;
    logic       pready, pslverr;
    logic       of_i = 1'b0, uf_i = 1'b0;
    logic       irq;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0] d;
    logic       rdy, err;
    int         hi_cnt;

    timer_intc #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .of_i(of_i), .uf_i(uf_i), .irq(irq)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // ev raises of_i/uf_i during the access cycle so the event lands on the commit edge.
    task automatic apb_write(input logic [7:0] a, input logic [7:0] wd, input logic [1:0] ev = 2'b00);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = wd;
        @(posedge pclk); #1;
        penable = 1'b1;
        if (ev[0]) of_i = 1'b1;
        if (ev[1]) uf_i = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        if (ev[0]) of_i = 1'b0;
        if (ev[1]) uf_i = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [7:0] rd, output logic r, output logic e);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        rd = prdata; r = pready; e = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] v;
        logic       r, e;
        apb_read(a, v, r, e);
        check(tag, {24'h0, v}, {24'h0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and defaults
        #50;
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_pready", {31'h0, pready}, 32'h0);
        check("rst_prdata", {24'h0, prdata}, 32'h0);
        #2 preset_n = 1'b1;
        tick(1);
        apb_read(INTC_IER, d, rdy, err);
        check("rst_ier", {24'h0, d}, 32'h0);
        check("rd_pready", {31'h0, rdy}, 32'h1);
        check("rd_pslverr", {31'h0, err}, 32'h0);
        rd_chk("rst_ipr", INTC_IPR, 8'h00);
        rd_chk("rst_icr", INTC_ICR, 8'h00);
        rd_chk("rst_ofcnt", INTC_OFCNT, 8'h00);
        rd_chk("rst_ufcnt", INTC_UFCNT, 8'h00);

        // Overflow in level mode
        apb_write(INTC_IER, 8'h01);
        apb_write(INTC_ICR, 8'h01);
        of_i = 1'b1;
        @(posedge pclk); @(negedge pclk);
        check("lvl_irq_edge1", {31'h0, irq}, 32'h0);
        @(negedge pclk);
        check("lvl_irq_edge2", {31'h0, irq}, 32'h1);
        rd_chk("lvl_ipr", INTC_IPR, 8'h01);
        rd_chk("lvl_ofcnt", INTC_OFCNT, 8'h01);
        apb_write(INTC_IPR, 8'h02);
        @(negedge pclk);
        check("clr_irq_hold", {31'h0, irq}, 32'h1);
        @(negedge pclk);
        check("clr_irq_low", {31'h0, irq}, 32'h0);
        of_i = 1'b0;
        rd_chk("clr_ipr", INTC_IPR, 8'h00);

        // Masking
        tick(1);
        uf_i = 1'b1;
        tick(1);
        uf_i = 1'b0;
        tick(2);
        rd_chk("mask_ipr", INTC_IPR, 8'h02);
        rd_chk("mask_ufcnt", INTC_UFCNT, 8'h01);
        @(negedge pclk);
        check("mask_irq", {31'h0, irq}, 32'h0);
        apb_write(INTC_IER, 8'h03);
        @(negedge pclk);
        check("unmask_irq_edge1", {31'h0, irq}, 32'h0);
        @(negedge pclk);
        check("unmask_irq_edge2", {31'h0, irq}, 32'h1);
        apb_write(INTC_IPR, 8'h00);
        tick(2);
        @(negedge pclk);
        check("unmask_clr_irq", {31'h0, irq}, 32'h0);

        // Pulse mode, simultaneous and held edges
        apb_write(INTC_ICR, 8'h03);
        of_i = 1'b1; uf_i = 1'b1;
        hi_cnt = 0;
        @(negedge pclk);
        @(negedge pclk);
        check("pulse_edge1", {31'h0, irq}, 32'h0);
        @(negedge pclk);
        check("pulse_edge2", {31'h0, irq}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            if (irq) hi_cnt++;
        end
        check("pulse_no_repeat", hi_cnt, 0);
        rd_chk("pulse_ipr", INTC_IPR, 8'h03);
        rd_chk("held_ofcnt", INTC_OFCNT, 8'h02);
        rd_chk("held_ufcnt", INTC_UFCNT, 8'h02);
        of_i = 1'b0; uf_i = 1'b0;

        // Set beats clear, event with counter clear, saturation
        apb_write(INTC_IPR, 8'h00);
        rd_chk("sbc_pre_ipr", INTC_IPR, 8'h00);
        apb_write(INTC_IPR, 8'h00, 2'b01);
        rd_chk("sbc_ipr", INTC_IPR, 8'h01);
        rd_chk("sbc_ofcnt", INTC_OFCNT, 8'h03);
        apb_write(INTC_OFCNT, 8'h00, 2'b01);
        rd_chk("clr_inc_ofcnt", INTC_OFCNT, 8'h01);
        for (int i = 0; i < 260; i++) begin
            of_i = 1'b1;
            tick(1);
            of_i = 1'b0;
            tick(1);
        end
        rd_chk("sat_ofcnt", INTC_OFCNT, 8'hFF);
        rd_chk("sat_ufcnt", INTC_UFCNT, 8'h02);
        apb_write(INTC_OFCNT, 8'h03);
        rd_chk("sat_clr_ofcnt", INTC_OFCNT, 8'h00);

        // Unmapped address
        apb_read(8'h07, d, rdy, err);
        check("err_prdata", {24'h0, d}, 32'h0);
        check("err_pready", {31'h0, rdy}, 32'h1);
        check("err_pslverr", {31'h0, err}, 32'h1);
        apb_write(8'h07, 8'hFF);
        rd_chk("err_ier_kept", INTC_IER, 8'h03);
        rd_chk("err_icr_kept", INTC_ICR, 8'h03);

        // Reset mid-ACCESS
        apb_write(INTC_ICR, 8'h01);
        tick(2);
        @(negedge pclk);
        check("pre_rst_irq", {31'h0, irq}, 32'h1);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = INTC_IPR;
        @(posedge pclk); #1;
        penable = 1'b1;
        #2;
        check("acc_pready", {31'h0, pready}, 32'h1);
        check("acc_prdata", {24'h0, prdata}, 32'h01);
        preset_n = 1'b0;
        #1;
        check("mid_rst_pready", {31'h0, pready}, 32'h0);
        check("mid_rst_prdata", {24'h0, prdata}, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        check("mid_rst_pslverr", {31'h0, pslverr}, 32'h0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        tick(2);
        preset_n = 1'b1;
        tick(1);
        rd_chk("post_rst_ipr", INTC_IPR, 8'h00);
        rd_chk("post_rst_ier", INTC_IER, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
